// File: rtl/reg_exec_pkg.sv
// -----------------------------------------------------------------------------
// reg_exec_pkg
// Shared definitions for the register execute unit: opcode type and encodings,
// the sequencing FSM state type and a small opcode legality helper.
// No ports (package).
// -----------------------------------------------------------------------------
package reg_exec_pkg;

    typedef logic [3:0] opcode_t;

    localparam opcode_t OP_ADD  = 4'd0;
    localparam opcode_t OP_ADDI = 4'd1;
    localparam opcode_t OP_SUBI = 4'd2;
    localparam opcode_t OP_SUB  = 4'd3;
    localparam opcode_t OP_AND  = 4'd4;
    localparam opcode_t OP_OR   = 4'd5;
    localparam opcode_t OP_XOR  = 4'd6;
    localparam opcode_t OP_SLT  = 4'd7;
    localparam opcode_t OP_MUL  = 4'd8;

    // state   | meaning
    // IDLE    | ready for a new instruction when the output slot is free
    // MUL     | iterative multiply in progress, upstream stalled
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

    function automatic logic op_is_legal(input opcode_t op);
        return (op <= OP_MUL);
    endfunction

endpackage

// File: rtl/reg_exec_unit_if.sv
// -----------------------------------------------------------------------------
// reg_exec_unit_if
// Bundles the instruction-in handshake, result-out handshake and debug read
// port of reg_exec_unit.
//   master : instruction source / result sink / debug reader
//   slave  : the execute unit
// Parameters: DATA_W (datapath width), NREGS (register count, power of two).
// -----------------------------------------------------------------------------
interface reg_exec_unit_if #(
    parameter int DATA_W = 16,
    parameter int NREGS  = 8
);
    import reg_exec_pkg::*;

    localparam int REG_AW = $clog2(NREGS);

    logic              in_valid;
    logic              in_ready;
    opcode_t           opcode;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [DATA_W-1:0] imm;

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_result;
    logic [REG_AW-1:0] out_rd;
    logic              out_zero;
    logic              out_carry;
    logic              out_ovf;
    logic              out_err;

    logic [REG_AW-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_data;

    modport master (
        output in_valid, opcode, rd, rs1, rs2, imm, out_ready, dbg_addr,
        input  in_ready, out_valid, out_result, out_rd, out_zero, out_carry,
               out_ovf, out_err, dbg_data
    );

    modport slave (
        input  in_valid, opcode, rd, rs1, rs2, imm, out_ready, dbg_addr,
        output in_ready, out_valid, out_result, out_rd, out_zero, out_carry,
               out_ovf, out_err, dbg_data
    );

endinterface

// File: rtl/reg_exec_unit_seq_mul.sv
// -----------------------------------------------------------------------------
// seq_mul
// Iterative shift-add multiplier producing the low DATA_W bits of an unsigned
// product, one partial product per cycle.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   start_i    : load operands and begin (ignored while rst)
//   a_i, b_i   : multiplicand, multiplier
//   finish_i   : owner consumes product_o this cycle; required to retire
//   last_o     : final step is pending; product_o is valid in this cycle
//   product_o  : accumulator including the current step
// -----------------------------------------------------------------------------
module seq_mul #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic              finish_i,
    output logic              last_o,
    output logic [DATA_W-1:0] product_o
);

    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    logic              active_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [DATA_W-1:0] acc_q;
    logic [DATA_W-1:0] mcand_q;
    logic [DATA_W-1:0] mplier_q;
    logic [DATA_W-1:0] step_sum;

    assign step_sum  = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign last_o    = active_q && (cnt_q == CNT_LAST);
    // The last step is folded into the product combinationally, so the
    // accumulator simply holds while the owner waits for its output slot.
    assign product_o = step_sum;

    always_ff @(posedge clk) begin
        if (rst) begin
            active_q <= 1'b0;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
        end else if (start_i) begin
            active_q <= 1'b1;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= a_i;
            mplier_q <= b_i;
        end else if (active_q) begin
            if (cnt_q != CNT_LAST) begin
                acc_q    <= step_sum;
                mcand_q  <= mcand_q << 1;
                mplier_q <= mplier_q >> 1;
                cnt_q    <= cnt_q + 1'b1;
            end else if (finish_i) begin
                active_q <= 1'b0;
                acc_q    <= step_sum;
                cnt_q    <= '0;
            end
        end
    end

endmodule

// File: rtl/reg_exec_unit.sv
// -----------------------------------------------------------------------------
// reg_exec_unit
// Register file plus execute stage: one register-register or
// register-immediate instruction per in handshake, result presented in a
// single-entry output slot with valid/ready flow control. MUL runs on the
// iterative seq_mul and stalls upstream until it retires.
// Ports:
//   clk  : system clock
//   rst  : synchronous active-high reset
//   bus  : reg_exec_unit_if.slave (instruction in, result out, debug read)
// -----------------------------------------------------------------------------
module reg_exec_unit
    import reg_exec_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int NREGS  = 8
) (
    input  logic            clk,
    input  logic            rst,
    reg_exec_unit_if.slave  bus
);

    localparam int REG_AW = $clog2(NREGS);
    localparam int MSB    = DATA_W - 1;

    logic [DATA_W-1:0] regs_q [NREGS];
    state_t            state_q, state_d;

    logic              out_valid_q;
    logic [DATA_W-1:0] out_result_q;
    logic [REG_AW-1:0] out_rd_q;
    logic              out_zero_q, out_carry_q, out_ovf_q, out_err_q;
    logic [REG_AW-1:0] mul_rd_q;

    logic              slot_free, in_ready, accept;
    logic              mul_start, mul_finish, mul_last, single_load;
    logic [DATA_W-1:0] mul_product;
    logic [DATA_W-1:0] opa, opb_reg, opb;
    logic [DATA_W:0]   sum_ext;
    logic [DATA_W-1:0] alu_res;
    logic              alu_carry, alu_ovf, alu_err;

    assign slot_free   = !out_valid_q || bus.out_ready;
    assign in_ready    = (state_q == ST_IDLE) && slot_free;
    assign accept      = bus.in_valid && in_ready;
    assign mul_start   = accept && (bus.opcode == OP_MUL);
    assign single_load = accept && (bus.opcode != OP_MUL);
    assign mul_finish  = (state_q == ST_MUL) && mul_last && slot_free;

    // Operands are read from the current register state, so rd==rs1/rs2
    // sees the value from before this instruction's write.
    assign opa     = regs_q[bus.rs1];
    assign opb_reg = regs_q[bus.rs2];

    always_comb begin
        alu_res   = '0;
        alu_carry = 1'b0;
        alu_ovf   = 1'b0;
        alu_err   = 1'b0;
        opb       = opb_reg;
        sum_ext   = '0;
        case (bus.opcode)
            OP_ADD, OP_ADDI: begin
                if (bus.opcode == OP_ADDI) opb = bus.imm;
                sum_ext   = {1'b0, opa} + {1'b0, opb};
                alu_res   = sum_ext[DATA_W-1:0];
                alu_carry = sum_ext[DATA_W];
                alu_ovf   = (opa[MSB] == opb[MSB]) && (alu_res[MSB] != opa[MSB]);
            end
            OP_SUB, OP_SUBI: begin
                if (bus.opcode == OP_SUBI) opb = bus.imm;
                sum_ext   = {1'b0, opa} - {1'b0, opb};
                alu_res   = sum_ext[DATA_W-1:0];
                alu_carry = sum_ext[DATA_W];
                alu_ovf   = (opa[MSB] != opb[MSB]) && (alu_res[MSB] != opa[MSB]);
            end
            OP_AND: alu_res = opa & opb_reg;
            OP_OR:  alu_res = opa | opb_reg;
            OP_XOR: alu_res = opa ^ opb_reg;
            OP_SLT: alu_res = {{(DATA_W-1){1'b0}}, ($signed(opa) < $signed(opb_reg))};
            OP_MUL: alu_res = '0;
            default: alu_err = 1'b1;
        endcase
    end

    seq_mul #(.DATA_W(DATA_W)) u_mul (
        .clk       (clk),
        .rst       (rst),
        .start_i   (mul_start),
        .a_i       (opa),
        .b_i       (opb_reg),
        .finish_i  (mul_finish),
        .last_o    (mul_last),
        .product_o (mul_product)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (mul_start)  state_d = ST_MUL;
            ST_MUL:  if (mul_finish) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_rd_q     <= '0;
            out_zero_q   <= 1'b0;
            out_carry_q  <= 1'b0;
            out_ovf_q    <= 1'b0;
            out_err_q    <= 1'b0;
            mul_rd_q     <= '0;
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else begin
            state_q <= state_d;
            if (mul_start) mul_rd_q <= bus.rd;

            if (single_load && !alu_err) regs_q[bus.rd] <= alu_res;
            else if (mul_finish)         regs_q[mul_rd_q] <= mul_product;

            if (single_load) begin
                out_valid_q  <= 1'b1;
                out_result_q <= alu_res;
                out_rd_q     <= bus.rd;
                out_zero_q   <= (alu_res == '0) && !alu_err;
                out_carry_q  <= alu_carry;
                out_ovf_q    <= alu_ovf;
                out_err_q    <= alu_err;
            end else if (mul_finish) begin
                out_valid_q  <= 1'b1;
                out_result_q <= mul_product;
                out_rd_q     <= mul_rd_q;
                out_zero_q   <= (mul_product == '0);
                out_carry_q  <= 1'b0;
                out_ovf_q    <= 1'b0;
                out_err_q    <= 1'b0;
            end else if (bus.out_ready) begin
                out_valid_q  <= 1'b0;
            end
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_result = out_result_q;
    assign bus.out_rd     = out_rd_q;
    assign bus.out_zero   = out_zero_q;
    assign bus.out_carry  = out_carry_q;
    assign bus.out_ovf    = out_ovf_q;
    assign bus.out_err    = out_err_q;
    assign bus.dbg_data   = regs_q[bus.dbg_addr];

endmodule

// File: tb/tb_reg_exec_unit.sv
// Directed and randomized checks of reg_exec_unit against a behavioural model.
module tb_reg_exec_unit;
    import reg_exec_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    reg_exec_unit_if #(.DATA_W(16), .NREGS(8)) bus ();
    reg_exec_unit #(.DATA_W(16), .NREGS(8)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct packed {
        logic [15:0] res;
        logic        carry;
        logic        ovf;
        logic        err;
        logic        zero;
        logic        wr;
    } exp_t;

    int          total = 0;
    int          bad   = 0;
    logic [15:0] mregs [8];

    // Behavioural reference: integer arithmetic on the instruction rules.
    function automatic exp_t model(input int op, input logic [15:0] a,
                                   input logic [15:0] b, input logic [15:0] imm);
        exp_t   e;
        int     ua, ub, u, sa, sb, s;
        longint p;
        e = '0;
        e.wr = 1'b1;
        ua = int'(a);
        ub = (op == 1 || op == 2) ? int'(imm) : int'(b);
        sa = int'($signed(a));
        sb = (op == 1 || op == 2) ? int'($signed(imm)) : int'($signed(b));
        case (op)
            0, 1: begin
                u = ua + ub; s = sa + sb;
                e.res = 16'(u); e.carry = (u > 65535); e.ovf = (s > 32767) || (s < -32768);
            end
            2, 3: begin
                u = ua - ub; s = sa - sb;
                e.res = 16'(u); e.carry = (u < 0); e.ovf = (s > 32767) || (s < -32768);
            end
            4: e.res = a & b;
            5: e.res = a | b;
            6: e.res = a ^ b;
            7: e.res = (sa < sb) ? 16'd1 : 16'd0;
            8: begin
                p = longint'(a) * longint'(b);
                e.res = 16'(p);
            end
            default: begin
                e.err = 1'b1; e.wr = 1'b0; e.res = 16'd0;
            end
        endcase
        e.zero = (e.res == 16'd0) && !e.err;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic check_out(input string tag, input exp_t e, input int rd);
        chk({tag, ".valid"},  32'(bus.out_valid),  32'd1);
        chk({tag, ".result"}, 32'(bus.out_result), 32'(e.res));
        if (!e.err) chk({tag, ".rd"}, 32'(bus.out_rd), 32'(rd));
        chk({tag, ".zero"},  32'(bus.out_zero),  32'(e.zero));
        chk({tag, ".carry"}, 32'(bus.out_carry), 32'(e.carry));
        chk({tag, ".ovf"},   32'(bus.out_ovf),   32'(e.ovf));
        chk({tag, ".err"},   32'(bus.out_err),   32'(e.err));
    endtask

    task automatic chk_dbg(input int a);
        bus.dbg_addr = 3'(a);
        #1;
        chk($sformatf("dbg_r%0d", a), 32'(bus.dbg_data), 32'(mregs[a]));
    endtask

    task automatic drive(input int op, input int rd, input int rs1, input int rs2,
                         input logic [15:0] imm);
        bus.in_valid = 1'b1;
        bus.opcode   = 4'(op);
        bus.rd       = 3'(rd);
        bus.rs1      = 3'(rs1);
        bus.rs2      = 3'(rs2);
        bus.imm      = imm;
    endtask

    // Instruction already accepted on the coming edge; check it one cycle later.
    task automatic finish_single(input string tag, input int op, input int rd,
                                 input int rs1, input int rs2, input logic [15:0] imm);
        exp_t e;
        e = model(op, mregs[rs1], mregs[rs2], imm);
        @(negedge clk);
        bus.in_valid = 1'b0;
        check_out(tag, e, rd);
        if (e.wr) mregs[rd] = e.res;
    endtask

    task automatic step_single(input string tag, input int op, input int rd,
                               input int rs1, input int rs2, input logic [15:0] imm);
        drive(op, rd, rs1, rs2, imm);
        #1;
        chk({tag, ".in_ready"}, 32'(bus.in_ready), 32'd1);
        finish_single(tag, op, rd, rs1, rs2, imm);
    endtask

    task automatic step_mul(input string tag, input int rd, input int rs1, input int rs2,
                            input bit nv, input int nop, input int nrd, input int nrs1,
                            input int nrs2, input logic [15:0] nimm);
        exp_t e;
        int   n, low;
        e = model(8, mregs[rs1], mregs[rs2], 16'd0);
        drive(8, rd, rs1, rs2, 16'd0);
        #1;
        chk({tag, ".in_ready"}, 32'(bus.in_ready), 32'd1);
        n = 0; low = 0;
        do begin
            @(negedge clk);
            n++;
            if (!bus.out_valid && !bus.in_ready) low++;
            if (n == 1) begin
                bus.in_valid = 1'b0;
                if (nv) drive(nop, nrd, nrs1, nrs2, nimm);
            end
            if (n == 8 && nv) chk_dbg(nrd);
        end while (!bus.out_valid && n < 40);
        chk({tag, ".latency"}, 32'(n), 32'd17);
        chk({tag, ".busy"},    32'(low), 32'd16);
        check_out(tag, e, rd);
        mregs[rd] = e.res;
        if (nv) begin
            chk({tag, ".held_ready"}, 32'(bus.in_ready), 32'd1);
            finish_single({tag, ".held"}, nop, nrd, nrs1, nrs2, nimm);
        end else begin
            bus.in_valid = 1'b0;
        end
    endtask

    initial begin
        int op, rd, rs1, rs2, n;
        logic [15:0] imm;

        rst = 1'b1;
        bus.in_valid = 1'b0; bus.opcode = '0; bus.rd = '0; bus.rs1 = '0; bus.rs2 = '0;
        bus.imm = '0; bus.out_ready = 1'b1; bus.dbg_addr = '0;
        for (int i = 0; i < 8; i++) mregs[i] = 16'd0;
        repeat (2) @(negedge clk);
        chk("rst.out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst.in_ready",  32'(bus.in_ready),  32'd1);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) chk_dbg(i);
        @(negedge clk);

        // 1: back-to-back single-cycle ops
        step_single("t1a", 1, 1, 0, 0, 16'd5);
        step_single("t1b", 1, 2, 0, 0, 16'd7);
        step_single("t1c", 0, 3, 1, 2, 16'd0);
        chk("t1c.const", 32'(bus.out_result), 32'd12);
        chk_dbg(3);

        // 2: overflow and borrow
        @(negedge clk);
        step_single("t2a", 1, 1, 0, 0, 16'h7FFF);
        step_single("t2b", 1, 2, 0, 0, 16'd1);
        step_single("t2c", 0, 3, 1, 2, 16'd0);
        chk("t2c.ovf_const", 32'(bus.out_ovf), 32'd1);
        step_single("t2d", 3, 4, 0, 2, 16'd0);
        chk("t2d.borrow_const", 32'(bus.out_carry), 32'd1);

        // 3: multiply with a held follower
        step_single("t3a", 1, 1, 0, 0, 16'd6);
        step_single("t3b", 1, 2, 0, 0, 16'd7);
        step_mul("t3mul", 3, 1, 2, 1'b1, 0, 4, 3, 1, 16'd0);
        chk_dbg(3);
        chk_dbg(4);

        // 4: output back-pressure
        @(negedge clk);
        bus.out_ready = 1'b0;
        step_single("t4a", 1, 5, 0, 0, 16'd9);
        drive(1, 6, 0, 0, 16'd3);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("t4.in_ready_low", 32'(bus.in_ready),   32'd0);
            chk("t4.hold_result",  32'(bus.out_result), 32'd9);
            chk("t4.hold_valid",   32'(bus.out_valid),  32'd1);
            chk_dbg(6);
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        #1;
        chk("t4.release_ready", 32'(bus.in_ready), 32'd1);
        finish_single("t4b", 1, 6, 0, 0, 16'd3);

        // 5: illegal opcode and signed compare
        step_single("t5ill", 12, 5, 1, 2, 16'd0);
        chk_dbg(5);
        step_single("t5a", 1, 1, 0, 0, 16'hFFFF);
        step_single("t5b", 1, 2, 0, 0, 16'd1);
        step_single("t5slt", 7, 7, 1, 2, 16'd0);
        chk("t5slt.const", 32'(bus.out_result), 32'd1);

        // random instructions against the model
        for (int k = 0; k < 60; k++) begin
            op  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(9, 15)) : int'($urandom_range(0, 8));
            rd  = $urandom_range(0, 7);
            rs1 = $urandom_range(0, 7);
            rs2 = $urandom_range(0, 7);
            imm = 16'($urandom);
            if (op == 8) step_mul($sformatf("rnd%0d", k), rd, rs1, rs2, 1'b0, 0, 0, 0, 0, 16'd0);
            else         step_single($sformatf("rnd%0d", k), op, rd, rs1, rs2, imm);
        end
        for (int i = 0; i < 8; i++) chk_dbg(i);

        // 6: reset during multiply
        @(negedge clk);
        step_single("t6a", 1, 1, 0, 0, 16'd3);
        step_single("t6b", 1, 2, 0, 0, 16'd5);
        step_single("t6c", 1, 6, 0, 0, 16'd11);
        drive(8, 6, 1, 2, 16'd0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("t6.out_valid", 32'(bus.out_valid), 32'd0);
        chk("t6.in_ready",  32'(bus.in_ready),  32'd1);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) mregs[i] = 16'd0;
        for (int i = 0; i < 8; i++) chk_dbg(i);
        n = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.out_valid) n++;
        end
        chk("t6.no_late_result", 32'(n), 32'd0);
        chk_dbg(6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/reg_exec_unit.md
Name: reg_exec_unit

Overview:
- Parametrised successor to the 8x16 register-file/ALU execute block.
- Holds NREGS registers of DATA_W bits and executes one register-register or register-immediate instruction per handshake.
- Adds logic ops, signed compare, an iterative multi-cycle multiply, status flags, valid/ready flow control on both sides, and a debug read port.
- Sits between the instruction decoder (upstream) and the write-back/trace logic (downstream).

Parameters:
- DATA_W, 16, register and datapath width in bits. Must be at least 4.
- NREGS, 8, number of registers. Must be a power of two and at least 2.
- REG_AW, $clog2(NREGS), register address width. Derived; not to be overridden.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  instruction present.
- in_ready  out  1  unit can accept an instruction this cycle.
- opcode  in  4  operation select.
- rd  in  REG_AW  destination register.
- rs1  in  REG_AW  source register 1.
- rs2  in  REG_AW  source register 2.
- imm  in  DATA_W  immediate operand.
- out_valid  out  1  result present.
- out_ready  in  1  downstream accepts the result.
- out_result  out  DATA_W  value written to rd.
- out_rd  out  REG_AW  destination register of out_result.
- out_zero  out  1  out_result is 0.
- out_carry  out  1  ADD/ADDI: carry-out. SUB/SUBI: borrow. Otherwise 0.
- out_ovf  out  1  signed overflow, ADD/ADDI/SUB/SUBI only. Otherwise 0.
- out_err  out  1  illegal opcode.
- dbg_addr  in  REG_AW  debug read address.
- dbg_data  out  DATA_W  combinational read of registers[dbg_addr].

Behaviour:
- Reset: all registers cleared to 0, FSM to IDLE, multiply counter cleared, all outputs 0. Reset mid-multiply aborts the operation with no register write.
- Accept condition: in_valid && in_ready. in_ready = (state==IDLE) && (!out_valid || out_ready).
- Opcodes:
  - 0 ADD: rs1+rs2
  - 1 ADDI: rs1+imm
  - 2 SUBI: rs1-imm
  - 3 SUB: rs1-rs2
  - 4 AND, 5 OR, 6 XOR: on rs1, rs2
  - 7 SLT: signed rs1<rs2 gives 1, else 0
  - 8 MUL: low DATA_W bits of rs1*rs2, unsigned
  - 9-15: illegal
- Arithmetic: all results truncated to DATA_W (wrap-around). Carry and borrow are taken from a DATA_W+1 bit sum. Overflow uses the standard sign rule.
- Single-cycle ops:
  - On the accept edge, registers[rd] is written and the out_* registers are loaded.
  - out_valid is high the following cycle (latency 1).
  - An instruction accepted next cycle reads the updated value, so there is no hazard.
- Illegal opcode: no register write; out_result=0; out_err=1; other flags 0; out_valid still asserted.
- MUL FSM (states IDLE, MUL):
  - On accept: capture multiplicand, multiplier and rd; clear the accumulator and cnt; go to MUL.
  - Each cycle in MUL: one shift-add step, cnt+1.
  - Completion condition: cnt==DATA_W-1 and the output slot is free (!out_valid || out_ready).
  - At completion: write rd, load out_*, return to IDLE. out_valid rises DATA_W cycles after accept when the slot is free.
  - If the slot is not free when cnt reaches DATA_W-1, stay in MUL with the accumulator held until it frees.
- Output slot:
  - out_valid clears on out_ready when no new result loads in the same cycle.
  - A result load in the same cycle as an out handshake replaces the data and keeps out_valid high.
  - out_* are stable while out_valid && !out_ready.
- rd==rs1 or rd==rs2: operands are read before the write, i.e. the old values are used.
- dbg_data reflects a write from the edge after that edge.

Decomposition:
- Shared package reg_exec_pkg holds:
  - opcode localparams OP_ADD..OP_MUL
  - an opcode_t 4-bit typedef
  - the FSM state enum.
- One sub-module, seq_mul (iterative shift-add multiplier with start/done), instantiated by reg_exec_unit.
- The ALU combinational function and the register array stay in the top module.

Test Plan:
1. Reset, then ADDI r1=r0+5; ADDI r2=r0+7; ADD r3=r1+r2 -> out_result 5, 7, 12 on consecutive cycles, each at latency 1; dbg_addr=3 reads 12.
2. ADDI r1=0x7FFF, ADDI r2=1, ADD r3=r1+r2 -> 0x8000 with out_ovf=1, carry=0. Then SUB r4=r0-r2 -> 0xFFFF with carry(borrow)=1.
3. r1=6, r2=7, MUL r3=r1*r2 -> in_ready low for 16 cycles, out_result 42. A second instruction held valid during MUL is accepted only after completion.
4. Hold out_ready=0 after one result -> in_ready=0, out_* stable, registers unchanged by the waiting instruction. Release -> waiting instruction accepted in the same cycle.
5. opcode 12 with rd=5 -> out_err=1, out_result=0, r5 unchanged; SLT with r1=-1 (0xFFFF), r2=1 -> 1.
6. Assert rst 5 cycles into a MUL -> next cycle out_valid=0, in_ready=1, all registers 0, no write to rd.
